// File: rtl/shift_frame_tx_if.sv
// Parallel-word handshake into the serialiser: the producer drives valid/data/order,
// and the serialiser answers with ready.
interface shift_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_msb_first;

    modport master (
        output in_valid,
        output in_data,
        output in_msb_first,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_msb_first,
        output in_ready
    );
endinterface

// File: rtl/shift_frame_tx.sv
// Serialiser: frames a parallel word as start/data/[parity]/stop bits on one line,
// each bit held CLKS_PER_BIT clocks, in LSB-first or MSB-first order chosen per word.
module shift_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    shift_frame_tx_if.slave   in_if,
    output logic              tx_serial,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity over the data word, inverted when odd parity is selected.
    function automatic logic calc_parity(input logic [DATA_W-1:0] word);
        return (^word) ^ (PARITY_ODD != 0);
    endfunction

    state_t            state_r,     state_s;
    logic [CNT_W-1:0]  clk_cnt_r,   clk_cnt_s;
    logic [BIT_W-1:0]  bit_cnt_r,   bit_cnt_s;
    logic [DATA_W-1:0] shift_r,     shift_s;
    logic              msb_first_r, msb_first_s;
    logic              parity_r,    parity_s;
    logic              tx_r,        tx_s;
    logic              busy_r,      busy_s;
    logic              done_r,      done_s;
    logic              accept_s;
    logic              bit_end_s;

    // Ready depends on state alone so a producer may wait on it without a comb loop.
    assign in_if.in_ready = (state_r == ST_IDLE);
    assign accept_s       = in_if.in_valid && (state_r == ST_IDLE);
    assign bit_end_s      = (clk_cnt_r == CNT_MAX);

    assign tx_serial = tx_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_s     = state_r;
        clk_cnt_s   = clk_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        msb_first_s = msb_first_r;
        parity_s    = parity_r;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clk_cnt_s = CNT_ZERO;
                bit_cnt_s = BIT_ZERO;
                if (accept_s) begin
                    state_s     = ST_START;
                    shift_s     = in_if.in_data;
                    msb_first_s = in_if.in_msb_first;
                    parity_s    = calc_parity(in_if.in_data);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s   = ST_DATA;
                    clk_cnt_s = CNT_ZERO;
                end else begin
                    clk_cnt_s = clk_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    clk_cnt_s = CNT_ZERO;
                    if (bit_cnt_r == BIT_MAX) begin
                        bit_cnt_s = BIT_ZERO;
                        state_s   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                        shift_s   = msb_first_r ? (shift_r << 1) : (shift_r >> 1);
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_s   = ST_STOP;
                    clk_cnt_s = CNT_ZERO;
                end else begin
                    clk_cnt_s = clk_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    state_s   = ST_IDLE;
                    clk_cnt_s = CNT_ZERO;
                    done_s    = 1'b1;
                end else begin
                    clk_cnt_s = clk_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                clk_cnt_s = CNT_ZERO;
                bit_cnt_s = BIT_ZERO;
            end
        endcase
    end

    // Line level is derived from the upcoming state so tx_serial can be a flop.
    always_comb begin
        tx_s   = 1'b1;
        busy_s = (state_s != ST_IDLE);
        case (state_s)
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = msb_first_s ? shift_s[DATA_W-1] : shift_s[0];
            ST_PARITY: tx_s = parity_s;
            ST_STOP:   tx_s = 1'b1;
            default:   tx_s = 1'b1;
        endcase
    end

    // State and output registers; reset forces the line high immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            clk_cnt_r   <= CNT_ZERO;
            bit_cnt_r   <= BIT_ZERO;
            shift_r     <= {DATA_W{1'b0}};
            msb_first_r <= 1'b0;
            parity_r    <= 1'b0;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            clk_cnt_r   <= clk_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            msb_first_r <= msb_first_s;
            parity_r    <= parity_s;
            tx_r        <= tx_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

endmodule

// File: tb/tb_shift_frame_tx.sv
// Directed bench for shift_frame_tx: three instances cover default, odd-parity and
// no-parity/one-clock-per-bit builds; frames are captured bit by bit off the line.
module tb_shift_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] valid = 3'b000;
    logic [2:0] msb = 3'b000;
    logic [7:0] data [3];
    wire  [2:0] ready;
    wire  [2:0] tx;
    wire  [2:0] busy;
    wire  [2:0] done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    shift_frame_tx_if #(.DATA_W(8)) if0 ();
    shift_frame_tx_if #(.DATA_W(8)) if1 ();
    shift_frame_tx_if #(.DATA_W(8)) if2 ();

    assign if0.in_valid = valid[0];
    assign if0.in_data = data[0];
    assign if0.in_msb_first = msb[0];
    assign ready[0] = if0.in_ready;
    assign if1.in_valid = valid[1];
    assign if1.in_data = data[1];
    assign if1.in_msb_first = msb[1];
    assign ready[1] = if1.in_ready;
    assign if2.in_valid = valid[2];
    assign if2.in_data = data[2];
    assign if2.in_msb_first = msb[2];
    assign ready[2] = if2.in_ready;

    shift_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .in_if(if0.slave),
        .tx_serial(tx[0]), .busy(busy[0]), .done(done[0])
    );
    shift_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
        .clk(clk), .reset(reset), .in_if(if1.slave),
        .tx_serial(tx[1]), .busy(busy[1]), .done(done[1])
    );
    shift_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
        .clk(clk), .reset(reset), .in_if(if2.slave),
        .tx_serial(tx[2]), .busy(busy[2]), .done(done[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one word for one accepting edge; returns at the first START cycle.
    task automatic send_word(input int d, input logic [7:0] w, input logic m);
        @(negedge clk);
        data[d]  = w;
        msb[d]   = m;
        valid[d] = 1'b1;
        @(negedge clk);
        valid[d] = 1'b0;
    endtask

    // Called at the first START cycle; returns at the negedge of the done cycle.
    task automatic capture_frame(input int d, input int cpb, input int nbits,
                                 input logic [15:0] exp_bits, input string tag);
        logic [15:0] bits;
        int busy_cnt;
        int glitch;
        int early_done;
        int idx;
        bit ended;
        bits = 16'h0000;
        busy_cnt = 0;
        glitch = 0;
        early_done = 0;
        ended = 1'b0;
        for (int cyc = 0; cyc < 400 && !ended; cyc++) begin
            if (busy[d] === 1'b1) begin
                idx = busy_cnt / cpb;
                if (idx < 16) begin
                    if ((busy_cnt % cpb) == 0) bits[idx] = tx[d];
                    else if (tx[d] !== bits[idx]) glitch++;
                end
                if (done[d] !== 1'b0) early_done++;
                busy_cnt++;
                @(negedge clk);
            end else begin
                ended = 1'b1;
            end
        end
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        check({tag, "_busy_cycles"}, busy_cnt, cpb * nbits);
        check({tag, "_bit_stable"}, glitch, 0);
        check({tag, "_done_early"}, early_done, 0);
        check({tag, "_done_pulse"}, 32'(done[d]), 32'd1);
        check({tag, "_done_tx"}, 32'(tx[d]), 32'd1);
        check({tag, "_done_ready"}, 32'(ready[d]), 32'd1);
    endtask

    // Line must stay idle (high, not busy, no done) for n cycles.
    task automatic check_idle(input int d, input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0) bad++;
        end
        check({tag, "_idle"}, bad, 0);
    endtask

    initial begin
        data[0] = 8'h00;
        data[1] = 8'h00;
        data[2] = 8'h00;

        // Reset state of all three builds
        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_tx%0d", d), 32'(tx[d]), 32'd1);
            check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
            check($sformatf("rst_done%0d", d), 32'(done[d]), 32'd0);
            check($sformatf("rst_ready%0d", d), 32'(ready[d]), 32'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        check_idle(0, 3, "post_rst");

        // 1: reset at cycle 10 of a frame (data bit 1 of 8'h35 = 0)
        send_word(0, 8'h35, 1'b0);
        repeat (10) @(negedge clk);
        check("midrst_pre_tx", 32'(tx[0]), 32'd0);
        check("midrst_pre_busy", 32'(busy[0]), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_tx", 32'(tx[0]), 32'd1);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_ready", 32'(ready[0]), 32'd1);
        check("midrst_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check_idle(0, 8, "midrst_after");

        // 2: LSB-first, even parity
        send_word(0, 8'h35, 1'b0);
        capture_frame(0, 4, 11, 16'h046A, "lsb_even");
        check_idle(0, 4, "lsb_even_after");

        // 3: MSB-first, odd parity
        send_word(1, 8'h35, 1'b1);
        capture_frame(1, 4, 11, 16'h0758, "msb_odd");
        check_idle(1, 4, "msb_odd_after");

        // 4: no parity, one clock per bit
        send_word(2, 8'hFF, 1'b0);
        capture_frame(2, 1, 10, 16'h03FE, "nopar_cpb1");
        check_idle(2, 4, "nopar_cpb1_after");

        // 5: back-to-back with valid held high; data changed mid-frame
        @(negedge clk);
        data[0]  = 8'h35;
        msb[0]   = 1'b0;
        valid[0] = 1'b1;
        @(negedge clk);
        data[0] = 8'hCA;
        capture_frame(0, 4, 11, 16'h046A, "b2b_first");
        @(negedge clk);
        valid[0] = 1'b0;
        capture_frame(0, 4, 11, 16'h0594, "b2b_second");
        check_idle(0, 6, "b2b_after");

        // 6: valid pulses with 8'h00 while busy are ignored
        send_word(0, 8'h35, 1'b0);
        fork
            capture_frame(0, 4, 11, 16'h046A, "busy_pulse");
            begin
                for (int p = 0; p < 3; p++) begin
                    repeat (8) @(negedge clk);
                    data[0]  = 8'h00;
                    msb[0]   = 1'b1;
                    valid[0] = 1'b1;
                    @(negedge clk);
                    valid[0] = 1'b0;
                end
            end
        join
        check_idle(0, 20, "busy_pulse_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
